// File: rtl/cb_pkg.sv
// Shared definitions for the credit-based link: transmitter state encoding and
// the credit-counter width helper used by both the transmitter and the FIFO.
package cb_pkg;

  typedef enum logic [1:0] {
    INIT    = 2'd0,
    ACTIVE  = 2'd1,
    DRAIN   = 2'd2,
    DRAINED = 2'd3
  } cb_tx_state_e;

  // Width needed to hold any count in 0..max_credits inclusive.
  function automatic int cb_credit_w(input int max_credits);
    return $clog2(max_credits + 1);
  endfunction

endpackage

// File: rtl/cb_credit_counter.sv
// Credit counter: load sets both the count and its ceiling; sends decrement,
// returns increment, and anything that would exceed the ceiling saturates and flags.
module cb_credit_counter #(
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  input  logic          count_en,
  input  logic          dec,
  input  logic          inc,
  output logic [CW-1:0] cnt,
  output logic [CW-1:0] cnt_max,
  output logic          err_ovf
);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] max_q, max_d;
  logic          err_ovf_q, err_ovf_d;
  logic [CW:0]   sum;

  always_comb begin
    // NOTE: every variable gets a default first, so no branch can infer a latch.
    cnt_d     = cnt_q;
    max_d     = max_q;
    err_ovf_d = err_ovf_q;
    // One extra bit so a return on top of a full counter is visible, not wrapped.
    sum = {1'b0, cnt_q} - {{CW{1'b0}}, dec} + {{CW{1'b0}}, inc};

    if (load) begin
      cnt_d = load_val;
      max_d = load_val;
    end else if (count_en) begin
      if (sum > {1'b0, max_q}) begin
        err_ovf_d = 1'b1;
        cnt_d     = max_q;
      end else begin
        cnt_d = sum[CW-1:0];
      end
    end

    if (inc && !count_en) err_ovf_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments for all state so every flop samples pre-edge values.
    if (!rst_n) begin
      cnt_q     <= '0;
      max_q     <= '0;
      err_ovf_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      max_q     <= max_d;
      err_ovf_q <= err_ovf_d;
    end
  end

  assign cnt     = cnt_q;
  assign cnt_max = max_q;
  assign err_ovf = err_ovf_q;

endmodule

// File: rtl/cb_credit_tx.sv
// Credit-based transmitter: forwards a ready/valid stream onto a valid-only link,
// sending only while it holds a credit from the downstream FIFO.
module cb_credit_tx
  import cb_pkg::*;
#(
  parameter int  DATA_W      = 32,
  parameter int  MAX_CREDITS = 8,
  localparam int CW          = cb_credit_w(MAX_CREDITS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  output logic              tx_valid,
  output logic [DATA_W-1:0] tx_data,
  input  logic              crd_ret,
  input  logic              crd_init_valid,
  input  logic [CW-1:0]     crd_init,
  input  logic              drain_req,
  output logic              drain_done,
  output logic [CW-1:0]     credits_avail,
  output logic [CW-1:0]     in_flight,
  output logic              err_cfg,
  output logic              err_crd_ovf
);

  localparam logic [CW-1:0] MAX_CRD = CW'(MAX_CREDITS);

  cb_tx_state_e      state_q, state_d;
  logic              tx_valid_q, tx_valid_d;
  logic [DATA_W-1:0] tx_data_q, tx_data_d;
  logic              drain_done_q, drain_done_d;
  logic              err_cfg_q, err_cfg_d;
  logic              load;
  logic              init_ok;
  logic              send;
  logic              count_en;
  logic [CW-1:0]     cnt;
  logic [CW-1:0]     crd_max;

  assign init_ok  = (crd_init != '0) && (crd_init <= MAX_CRD);
  assign count_en = (state_q == ACTIVE) || (state_q == DRAIN);
  // Ready looks only at the registered count: a same-cycle return never bypasses.
  assign s_ready  = (state_q == ACTIVE) && (cnt != '0) && !drain_req;
  assign send     = s_valid && s_ready;

  cb_credit_counter #(
    .CW (CW)
  ) u_counter (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .load_val (crd_init),
    .count_en (count_en),
    .dec      (send),
    .inc      (crd_ret),
    .cnt      (cnt),
    .cnt_max  (crd_max),
    .err_ovf  (err_crd_ovf)
  );

  always_comb begin
    state_d    = state_q;
    err_cfg_d  = err_cfg_q;
    load       = 1'b0;
    tx_valid_d = send;
    tx_data_d  = send ? s_data : tx_data_q;

    case (state_q)
      INIT: begin
        if (crd_init_valid) begin
          if (init_ok) begin
            load    = 1'b1;
            state_d = ACTIVE;
          end else begin
            err_cfg_d = 1'b1;
          end
        end
      end
      ACTIVE:  if (drain_req) state_d = DRAIN;
      // Every credit home and nothing still on the wire.
      DRAIN:   if ((cnt == crd_max) && !tx_valid_q) state_d = DRAINED;
      DRAINED: if (!drain_req) state_d = INIT;
      default: state_d = INIT;
    endcase

    drain_done_d = (state_d == DRAINED);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= INIT;
      tx_valid_q   <= 1'b0;
      tx_data_q    <= '0;
      drain_done_q <= 1'b0;
      err_cfg_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      tx_valid_q   <= tx_valid_d;
      tx_data_q    <= tx_data_d;
      drain_done_q <= drain_done_d;
      err_cfg_q    <= err_cfg_d;
    end
  end

  assign tx_valid      = tx_valid_q;
  assign tx_data       = tx_data_q;
  assign drain_done    = drain_done_q;
  assign err_cfg       = err_cfg_q;
  assign credits_avail = cnt;
  assign in_flight     = crd_max - cnt;

  a_no_send_empty: assert property (@(posedge clk) disable iff (!rst_n) send |-> (cnt != '0));
  a_tx_has_send:   assert property (@(posedge clk) disable iff (!rst_n) tx_valid_q |-> $past(send));
  a_in_flight_max: assert property (@(posedge clk) disable iff (!rst_n) in_flight <= crd_max);

endmodule

// File: tb/tb_cb_credit_tx.sv
// Directed bench for cb_credit_tx: a driver queues expected link words on each
// accepted source word, and a monitor pops and compares on every tx_valid pulse.
module tb_cb_credit_tx;

  localparam int DATA_W = 32;
  localparam int CW     = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] s_data;
  logic              tx_valid;
  logic [DATA_W-1:0] tx_data;
  logic              crd_ret;
  logic              crd_init_valid;
  logic [CW-1:0]     crd_init;
  logic              drain_req;
  logic              drain_done;
  logic [CW-1:0]     credits_avail;
  logic [CW-1:0]     in_flight;
  logic              err_cfg;
  logic              err_crd_ovf;

  int n_vec    = 0;
  int n_miss   = 0;
  int tx_count = 0;
  logic [DATA_W-1:0] sb_q[$];

  always #5 clk = ~clk;

  cb_credit_tx #(
    .DATA_W      (DATA_W),
    .MAX_CREDITS (8)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .s_valid        (s_valid),
    .s_ready        (s_ready),
    .s_data         (s_data),
    .tx_valid       (tx_valid),
    .tx_data        (tx_data),
    .crd_ret        (crd_ret),
    .crd_init_valid (crd_init_valid),
    .crd_init       (crd_init),
    .drain_req      (drain_req),
    .drain_done     (drain_done),
    .credits_avail  (credits_avail),
    .in_flight      (in_flight),
    .err_cfg        (err_cfg),
    .err_crd_ovf    (err_crd_ovf)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every link word must match the oldest accepted source word.
  always @(negedge clk) begin
    if (tx_valid === 1'b1) begin
      tx_count++;
      if (sb_q.size() == 0) begin
        n_vec++;
        n_miss++;
        $display("FAIL tx_unexpected: got 0x%0h, expected no word", tx_data);
      end else begin
        check("tx_data", tx_data, sb_q.pop_front());
      end
    end
  end

  // One clock: record the handshake mid-cycle, then step to just after the edge.
  task automatic tick(output bit hs);
    @(negedge clk);
    hs = (rst_n === 1'b1) && (s_valid === 1'b1) && (s_ready === 1'b1);
    if (hs) sb_q.push_back(s_data);
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    bit hs;
    for (int i = 0; i < n; i++) tick(hs);
  endtask

  task automatic do_reset();
    rst_n          = 1'b0;
    s_valid        = 1'b0;
    s_data         = '0;
    crd_ret        = 1'b0;
    crd_init_valid = 1'b0;
    crd_init       = '0;
    drain_req      = 1'b0;
    ticks(2);
    rst_n = 1'b1;
  endtask

  task automatic init_credits(input logic [CW-1:0] val);
    crd_init_valid = 1'b1;
    crd_init       = val;
    ticks(1);
    crd_init_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected bench completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit hs;
    int start;
    int idx;
    int cyc;
    bit ret_next;

    // Reset values
    do_reset();
    check("rst_tx_valid", 32'(tx_valid), 32'd0);
    check("rst_tx_data", tx_data, 32'd0);
    check("rst_drain_done", 32'(drain_done), 32'd0);
    check("rst_err_cfg", 32'(err_cfg), 32'd0);
    check("rst_err_ovf", 32'(err_crd_ovf), 32'd0);
    check("rst_credits", 32'(credits_avail), 32'd0);
    check("rst_s_ready", 32'(s_ready), 32'd0);

    // Init with 8 credits, offer 10 words, no returns
    init_credits(4'd8);
    check("fill_init_credits", 32'(credits_avail), 32'd8);
    check("fill_init_in_flight", 32'(in_flight), 32'd0);
    start = tx_count;
    for (int i = 0; i < 10; i++) begin
      s_valid = 1'b1;
      s_data  = 32'h100 + 32'(i);
      tick(hs);
    end
    #1;
    check("fill_s_ready_empty", 32'(s_ready), 32'd0);
    s_valid = 1'b0;
    ticks(2);
    check("fill_tx_pulses", 32'(tx_count - start), 32'd8);
    check("fill_credits", 32'(credits_avail), 32'd0);
    check("fill_in_flight", 32'(in_flight), 32'd8);

    // Steady state: 2 credits, return one credit the cycle after each send
    do_reset();
    init_credits(4'd2);
    idx = 0;
    cyc = 0;
    ret_next = 1'b0;
    while (idx < 16 && cyc < 100) begin
      s_valid = 1'b1;
      s_data  = 32'hA0 + 32'(idx);
      crd_ret = ret_next;
      tick(hs);
      ret_next = hs;
      if (hs) idx++;
      cyc++;
      if (credits_avail > 4'd2) check("steady_credit_range", 32'(credits_avail), 32'd2);
    end
    check("steady_words_sent", 32'(idx), 32'd16);
    check("steady_full_rate_cycles", 32'(cyc), 32'd16);
    s_valid = 1'b0;
    crd_ret = ret_next;
    ticks(1);
    crd_ret = 1'b0;
    ticks(1);
    check("steady_credits_home", 32'(credits_avail), 32'd2);
    check("steady_err_ovf", 32'(err_crd_ovf), 32'd0);

    // Simultaneous send and return; then no bypass at zero credits
    do_reset();
    init_credits(4'd2);
    s_valid = 1'b1;
    s_data  = 32'hC0;
    tick(hs);
    check("simul_first_send", 32'(credits_avail), 32'd1);
    s_data  = 32'hC1;
    crd_ret = 1'b1;
    tick(hs);
    check("simul_send_and_ret", 32'(credits_avail), 32'd1);
    s_data  = 32'hC2;
    crd_ret = 1'b0;
    tick(hs);
    check("simul_zero", 32'(credits_avail), 32'd0);
    s_data  = 32'hC3;
    crd_ret = 1'b1;
    #1;
    check("simul_no_bypass", 32'(s_ready), 32'd0);
    tick(hs);
    crd_ret = 1'b0;
    #1;
    check("simul_ready_next", 32'(s_ready), 32'd1);
    tick(hs);
    s_valid = 1'b0;
    crd_ret = 1'b1;
    ticks(2);
    crd_ret = 1'b0;
    ticks(1);
    check("simul_credits_home", 32'(credits_avail), 32'd2);

    // Bad init values, then a good one
    do_reset();
    s_valid = 1'b1;
    s_data  = 32'hBAD0;
    init_credits(4'd0);
    check("badinit_zero_err", 32'(err_cfg), 32'd1);
    check("badinit_zero_ready", 32'(s_ready), 32'd0);
    init_credits(4'd9);
    check("badinit_nine_credits", 32'(credits_avail), 32'd0);
    check("badinit_nine_ready", 32'(s_ready), 32'd0);
    s_valid = 1'b0;
    init_credits(4'd4);
    check("badinit_good_credits", 32'(credits_avail), 32'd4);
    check("badinit_good_ready", 32'(s_ready), 32'd1);
    check("badinit_err_sticky", 32'(err_cfg), 32'd1);

    // Return with every credit already home
    crd_ret = 1'b1;
    ticks(1);
    crd_ret = 1'b0;
    ticks(1);
    check("ovf_flag", 32'(err_crd_ovf), 32'd1);
    check("ovf_credits", 32'(credits_avail), 32'd4);
    check("ovf_in_flight", 32'(in_flight), 32'd0);

    // Drain with 3 words in flight
    do_reset();
    init_credits(4'd4);
    for (int i = 0; i < 3; i++) begin
      s_valid = 1'b1;
      s_data  = 32'hD0 + 32'(i);
      tick(hs);
    end
    s_data    = 32'hDF;
    drain_req = 1'b1;
    #1;
    check("drain_s_ready", 32'(s_ready), 32'd0);
    ticks(2);
    check("drain_not_done", 32'(drain_done), 32'd0);
    crd_ret = 1'b1;
    ticks(3);
    crd_ret = 1'b0;
    check("drain_at_third_ret", 32'(drain_done), 32'd0);
    ticks(1);
    check("drain_done_rise", 32'(drain_done), 32'd1);
    check("drain_done_ready", 32'(s_ready), 32'd0);
    drain_req = 1'b0;
    ticks(1);
    check("drain_exit_done", 32'(drain_done), 32'd0);
    check("drain_exit_ready", 32'(s_ready), 32'd0);

    // Reset in the middle of a stream
    s_valid = 1'b0;
    init_credits(4'd0);
    init_credits(4'd4);
    for (int i = 0; i < 2; i++) begin
      s_valid = 1'b1;
      s_data  = 32'hE0 + 32'(i);
      tick(hs);
    end
    rst_n = 1'b0;
    tick(hs);
    check("midrst_tx_valid", 32'(tx_valid), 32'd0);
    check("midrst_tx_data", tx_data, 32'd0);
    check("midrst_credits", 32'(credits_avail), 32'd0);
    check("midrst_in_flight", 32'(in_flight), 32'd0);
    check("midrst_err_cfg", 32'(err_cfg), 32'd0);
    check("midrst_s_ready", 32'(s_ready), 32'd0);
    rst_n   = 1'b1;
    s_valid = 1'b0;
    ticks(2);

    check("sb_leftover", 32'(sb_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
